// File: rtl/stopwatch_lap.sv
// Tenths-of-second BCD stopwatch with lap freeze, debounced buttons and a scanned 7-segment
// display. Build macro STOPWATCH_BLANK_EN enables leading-zero blanking of digits 2 and up.
module stopwatch_lap #(
    parameter int unsigned TICK_DIV  = 1_000_000,
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DEB_DIV   = 1_048_576,
    parameter int unsigned SCAN_BITS = 19,
    parameter int unsigned WRAP      = 1
) (
    input  logic              clk0,
    input  logic              reset_sw,
    input  logic              start_sw,
    input  logic              lap_sw,
    output logic [1:0]        led,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] line,
    output logic              dp
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEB_DIV);
    localparam int unsigned IW = $clog2(DIGITS);

    localparam logic [PW-1:0] TickMax = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DebMax  = DW'(DEB_DIV - 1);
    localparam logic [IW-1:0] IdxMax  = IW'(DIGITS - 1);

    typedef enum logic [1:0] {StStop, StRun, StLap} state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [DIGITS-1:0][3:0] digits_q, digits_d;
    logic [DIGITS-1:0][3:0] snap_q, snap_d;
    logic                   ovf_q, ovf_d;

    logic [DW-1:0]          deb_q, deb_d;
    logic [4:0]             sh_start_q, sh_start_d;
    logic [4:0]             sh_lap_q, sh_lap_d;
    logic                   clean_start_q, clean_start_d;
    logic                   clean_lap_q, clean_lap_d;
    logic                   press_start_q, press_lap_q;

    logic [SCAN_BITS-1:0]   slot_q, slot_d;
    logic [IW-1:0]          idx_q, idx_d;

    logic [1:0]             led_d;
    logic [6:0]             seg_d;
    logic [DIGITS-1:0]      line_d;
    logic                   dp_d;

    logic                   strobe;
    logic                   running;
    logic                   tick;
    logic                   all_nine;
    logic [DIGITS-1:0][3:0] inc;
    logic [DIGITS-1:0][3:0] src;
`ifdef STOPWATCH_BLANK_EN
    logic [DIGITS-1:0]      blank;
    logic                   upper_zero;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Both buttons share one sample strobe; clean level holds until five equal samples agree.
    always_comb begin
        strobe        = (deb_q == DebMax);
        deb_d         = strobe ? '0 : deb_q + 1'b1;
        sh_start_d    = strobe ? {sh_start_q[3:0], start_sw} : sh_start_q;
        sh_lap_d      = strobe ? {sh_lap_q[3:0], lap_sw} : sh_lap_q;
        clean_start_d = (&sh_start_d) ? 1'b1 : (~|sh_start_d) ? 1'b0 : clean_start_q;
        clean_lap_d   = (&sh_lap_d) ? 1'b1 : (~|sh_lap_d) ? 1'b0 : clean_lap_q;
    end

    // Ripple BCD increment; carry out of the top digit means the count was all nines.
    always_comb begin
        logic carry;
        carry = 1'b1;
        inc   = digits_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (carry) begin
                if (digits_q[k] == 4'd9) begin
                    inc[k] = 4'd0;
                end else begin
                    inc[k] = digits_q[k] + 4'd1;
                    carry  = 1'b0;
                end
            end
        end
        all_nine = carry;
    end

    always_comb begin
        running  = (state_q != StStop);
        tick     = running && (presc_q == TickMax);
        presc_d  = presc_q;
        if (running) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        state_d  = state_q;
        digits_d = digits_q;
        snap_d   = snap_q;
        ovf_d    = ovf_q;

        case (state_q)
            StStop: begin
                if (press_start_q) begin
                    state_d = StRun;
                end else if (press_lap_q) begin
                    digits_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            StRun: begin
                if (press_start_q) begin
                    state_d = StStop;
                end else if (press_lap_q) begin
                    state_d = StLap;
                    snap_d  = digits_q;
                end
            end
            StLap: begin
                if (press_start_q) begin
                    state_d = StStop;
                end else if (press_lap_q) begin
                    state_d = StRun;
                end
            end
            default: state_d = StStop;
        endcase

        // Saturation forces STOP even if a button asked for another state this cycle.
        if (tick) begin
            if (!all_nine || WRAP != 0) begin
                digits_d = inc;
            end
            if (all_nine) begin
                ovf_d = 1'b1;
                if (WRAP == 0) begin
                    state_d = StStop;
                end
            end
        end
    end

    always_comb begin
        slot_d = slot_q + 1'b1;
        idx_d  = idx_q;
        if (&slot_q) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end
    end

    // Display is built from next-state values so it switches on the same edge as the FSM.
    always_comb begin
        src    = (state_d == StLap) ? snap_d : digits_d;
        line_d = DIGITS'(1) << idx_d;
        dp_d   = (idx_d == IW'(1));
        led_d  = {ovf_d, state_d != StStop};
        seg_d  = seg_decode(src[idx_d]);
`ifdef STOPWATCH_BLANK_EN
        upper_zero = 1'b1;
        blank      = '0;
        for (int k = int'(DIGITS) - 1; k >= 2; k--) begin
            upper_zero = upper_zero & (src[k] == 4'd0);
            blank[k]   = upper_zero;
        end
        if (blank[idx_d]) begin
            seg_d = 7'b0000000;
        end
`endif
    end

    always_ff @(posedge clk0) begin
        if (reset_sw) begin
            state_q       <= StStop;
            presc_q       <= '0;
            digits_q      <= '0;
            snap_q        <= '0;
            ovf_q         <= 1'b0;
            deb_q         <= '0;
            sh_start_q    <= '0;
            sh_lap_q      <= '0;
            clean_start_q <= 1'b0;
            clean_lap_q   <= 1'b0;
            press_start_q <= 1'b0;
            press_lap_q   <= 1'b0;
            slot_q        <= '0;
            idx_q         <= '0;
            led           <= 2'b00;
            seg           <= 7'b1111110;
            line          <= DIGITS'(1);
            dp            <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            digits_q      <= digits_d;
            snap_q        <= snap_d;
            ovf_q         <= ovf_d;
            deb_q         <= deb_d;
            sh_start_q    <= sh_start_d;
            sh_lap_q      <= sh_lap_d;
            clean_start_q <= clean_start_d;
            clean_lap_q   <= clean_lap_d;
            press_start_q <= clean_start_d & ~clean_start_q;
            press_lap_q   <= clean_lap_d & ~clean_lap_q;
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            led           <= led_d;
            seg           <= seg_d;
            line          <= line_d;
            dp            <= dp_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Scoreboard bench: a cycle-level reference model of two stopwatches (wrap and saturate)
// queues the expected display every clock; a monitor pops and compares on the falling edge.
module tb_stopwatch_lap;

    localparam int unsigned TickDiv  = 4;
    localparam int unsigned Digits   = 4;
    localparam int unsigned DebDiv   = 2;
    localparam int unsigned ScanBits = 2;
    localparam int          CntMax   = 9999;

    logic              clk0 = 1'b0;
    logic              reset_sw;
    logic              start_sw;
    logic              lap_sw;
    logic [1:0]        led_w, led_s;
    logic [6:0]        seg_w, seg_s;
    logic [Digits-1:0] line_w, line_s;
    logic              dp_w, dp_s;

    stopwatch_lap #(
        .TICK_DIV (TickDiv),
        .DIGITS   (Digits),
        .DEB_DIV  (DebDiv),
        .SCAN_BITS(ScanBits),
        .WRAP     (1)
    ) dut_w (
        .clk0    (clk0),
        .reset_sw(reset_sw),
        .start_sw(start_sw),
        .lap_sw  (lap_sw),
        .led     (led_w),
        .seg     (seg_w),
        .line    (line_w),
        .dp      (dp_w)
    );

    stopwatch_lap #(
        .TICK_DIV (TickDiv),
        .DIGITS   (Digits),
        .DEB_DIV  (DebDiv),
        .SCAN_BITS(ScanBits),
        .WRAP     (0)
    ) dut_s (
        .clk0    (clk0),
        .reset_sw(reset_sw),
        .start_sw(start_sw),
        .lap_sw  (lap_sw),
        .led     (led_s),
        .seg     (seg_s),
        .line    (line_s),
        .dp      (dp_s)
    );

    always #5 clk0 = ~clk0;

    // st: 0 stop, 1 run, 2 lap; cnt and snap are plain integers 0..9999.
    typedef struct packed {
        int deb;
        int hs;
        int hl;
        bit cs;
        bit cl;
        bit ps;
        bit pl;
        int st;
        int presc;
        int cnt;
        int snap;
        bit ovf;
        int slot;
        int idx;
    } mdl_t;

    typedef struct packed {
        logic [1:0]        led;
        logic [Digits-1:0] line;
        logic [6:0]        seg;
        logic              dp;
    } exp_t;

    mdl_t  m_w, m_s;
    exp_t  q_w[$];
    exp_t  q_s[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    armed = 0;
    string phase = "reset";

    function automatic logic [6:0] seg_ref(int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit rst, bit s_raw, bit l_raw, bit wrap);
        mdl_t n;
        bit   strobe, running, tick;
        if (rst) begin
            n = '0;
            return n;
        end
        n       = m;
        strobe  = (m.deb == int'(DebDiv) - 1);
        n.deb   = strobe ? 0 : m.deb + 1;
        if (strobe) begin
            n.hs = ((m.hs << 1) | int'(s_raw)) & 31;
            n.hl = ((m.hl << 1) | int'(l_raw)) & 31;
        end
        if (n.hs == 31) n.cs = 1; else if (n.hs == 0) n.cs = 0;
        if (n.hl == 31) n.cl = 1; else if (n.hl == 0) n.cl = 0;
        n.ps = n.cs && !m.cs;
        n.pl = n.cl && !m.cl;

        running = (m.st != 0);
        tick    = running && (m.presc == int'(TickDiv) - 1);
        if (running) n.presc = tick ? 0 : m.presc + 1;

        if (m.ps) begin
            n.st = (m.st == 0) ? 1 : 0;
        end else if (m.pl) begin
            if (m.st == 0) begin
                n.cnt = 0;
                n.ovf = 0;
            end else if (m.st == 1) begin
                n.st   = 2;
                n.snap = m.cnt;
            end else begin
                n.st = 1;
            end
        end

        if (tick) begin
            if (m.cnt == CntMax) begin
                n.ovf = 1;
                if (wrap) n.cnt = 0;
                else n.st = 0;
            end else begin
                n.cnt = m.cnt + 1;
            end
        end

        n.slot = (m.slot + 1) % (1 << ScanBits);
        if (m.slot == (1 << ScanBits) - 1) n.idx = (m.idx + 1) % int'(Digits);
        return n;
    endfunction

    function automatic exp_t mdl_view(mdl_t m);
        exp_t e;
        int   src, div;
        src = (m.st == 2) ? m.snap : m.cnt;
        div = 1;
        for (int i = 0; i < m.idx; i++) div = div * 10;
        e.seg = seg_ref((src / div) % 10);
`ifdef STOPWATCH_BLANK_EN
        if (m.idx >= 2 && (src / div) == 0) e.seg = 7'b0000000;
`endif
        e.line = Digits'(1 << m.idx);
        e.dp   = (m.idx == 1);
        e.led  = {m.ovf, m.st != 0};
        return e;
    endfunction

    task automatic check(string tag, exp_t e, logic [1:0] led, logic [Digits-1:0] line,
                         logic [6:0] seg, logic dp);
        total++;
        if (led !== e.led || line !== e.line || seg !== e.seg || dp !== e.dp) begin
            bad++;
            $display("FAIL %s/%s cycle %0d: got led=%b line=%b seg=%b dp=%b, want led=%b line=%b seg=%b dp=%b",
                     tag, phase, cyc, led, line, seg, dp, e.led, e.line, e.seg, e.dp);
        end
    endtask

    // Reference model: advances on every rising edge from the bench's own stimulus.
    initial begin
        forever begin
            @(posedge clk0);
            cyc++;
            m_w = mdl_step(m_w, reset_sw, start_sw, lap_sw, 1'b1);
            m_s = mdl_step(m_s, reset_sw, start_sw, lap_sw, 1'b0);
            if (reset_sw) armed = 1;
            if (armed) begin
                q_w.push_back(mdl_view(m_w));
                q_s.push_back(mdl_view(m_s));
            end
        end
    end

    // Monitor: the display presents a new frame every cycle; compare away from the edge.
    initial begin
        forever begin
            @(negedge clk0);
            if (q_w.size() > 0) check("wrap", q_w.pop_front(), led_w, line_w, seg_w, dp_w);
            if (q_s.size() > 0) check("sat", q_s.pop_front(), led_s, line_s, seg_s, dp_s);
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk0);
    endtask

    task automatic press(bit s, bit l, int hold);
        start_sw = s;
        lap_sw   = l;
        idle(hold);
        start_sw = 1'b0;
        lap_sw   = 1'b0;
        idle($urandom_range(12, 20));
    endtask

    // Drives one raw value per debounce sample.
    task automatic bounce(bit on_start, int pattern, int len);
        for (int i = len - 1; i >= 0; i--) begin
            if (on_start) start_sw = pattern[i];
            else lap_sw = pattern[i];
            idle(DebDiv);
        end
        start_sw = 1'b0;
        lap_sw   = 1'b0;
        idle(12);
    endtask

    initial begin
        int waited;
        reset_sw = 1'b1;
        start_sw = 1'b0;
        lap_sw   = 1'b0;
        idle(3);
        reset_sw = 1'b0;
        phase = "stop_idle";
        idle(10);

        phase = "start_run";
        press(1, 0, 20);
        idle(40);
        phase = "stop_hold";
        press(1, 0, 20);
        idle(20);

        phase = "bounce";
        bounce(1, 5'b10101, 5);
        bounce(1, 4'b1101, 4);
        bounce(0, 5'b11011, 5);
        phase = "held_toggle";
        bounce(1, 5'b11111, 5);
        idle(16);
        press(1, 0, 12);

        phase = "lap_freeze";
        press(1, 0, 12);
        idle(10);
        press(0, 1, 12);
        idle(40);
        press(0, 1, 12);
        idle(20);

        phase = "both_pressed";
        press(1, 1, 14);
        idle(20);
        press(0, 1, 12);

        phase = "random";
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: press(1, 0, $urandom_range(4, 24));
                1: press(0, 1, $urandom_range(4, 24));
                2: bounce($urandom_range(0, 1) == 1, int'($urandom_range(0, 31)), 5);
                default: idle($urandom_range(5, 60));
            endcase
        end

        phase = "reset_mid";
        press(1, 0, 12);
        idle(30);
        start_sw = 1'b1;
        reset_sw = 1'b1;
        idle(1);
        reset_sw = 1'b0;
        idle(4);
        start_sw = 1'b0;
        idle(20);

        phase = "run_to_full";
        reset_sw = 1'b1;
        idle(2);
        reset_sw = 1'b0;
        idle(4);
        press(1, 0, 12);
        waited = 0;
        while (!(m_s.ovf && m_s.st == 0) && waited < 42000) begin
            idle(1);
            waited++;
        end
        total++;
        if (waited >= 42000) begin
            bad++;
            $display("FAIL run_to_full: waited %0d cycles, want saturation within 42000", waited);
        end
        idle(30);

        phase = "overflow_clear";
        press(1, 0, 12);
        idle(20);
        press(0, 1, 12);
        idle(20);

        phase = "low_count";
        press(1, 0, 12);
        idle($urandom_range(10, 40));
        press(1, 0, 12);
        idle(40);

        // Nothing is pushed without a rising edge, so the queues should be empty by now.
        @(negedge clk0);
        #2;
        total++;
        if (q_w.size() + q_s.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, want 0", q_w.size() + q_s.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
